uart_tx_fifo_param: RTL
=======================

// Module: uart_tx_fifo_param
// PURPOSE
//   Parametrised UART transmitter with an input FIFO. Next generation of the
//   single-byte TX used by the tb_ifc bench. Data width, stop bits, baud
//   divisor and FIFO depth are configurable; parity is an optional build
//   feature. Frames are sent back-to-back while the FIFO holds data. Sits
//   between the bus-side producer and the serial pad, ahead of the UART RX.
// PARAMETERS
//   CLKS_PER_BIT  87  clk cycles per serial bit, >=2
//   DATA_BITS     8   data bits per frame, 5..9, LSB first
//   STOP_BITS     1   stop bits per frame, 1 or 2
//   DEPTH         8   FIFO entries, power of 2, >=2
//   PARITY_ODD    0   1=odd, 0=even; used only with UART_PARITY_EN
// PORTS
//   clk              in   1                 clock, rising edge
//   i_Rst_L          in   1                 async reset, active low
//   i_TX_Data_Valid  in   1                 push request
//   i_TX_Byte        in   DATA_BITS         push data
//   o_TX_Ready       out  1                 FIFO not full (count<DEPTH)
//   o_FIFO_Count     out  $clog2(DEPTH)+1   entries held, 0..DEPTH
//   o_Overflow       out  1                 sticky: push dropped while full
//   o_TX_Active      out  1                 frame in progress
//   o_TX_Serial      out  1                 serial line, idle high
//   o_TX_Done        out  1                 1-cycle pulse per frame sent
// BEHAVIOUR
// - Reset (async assert, sync release): o_TX_Serial=1, o_TX_Ready=1,
//   o_FIFO_Count=0, o_Overflow=0, o_TX_Active=0, o_TX_Done=0; FSM=IDLE;
//   bit/baud counters=0. Mid-frame reset aborts the frame; line goes high
//   at once; FIFO contents are discarded.
// - Push: accepted at a rising edge when i_TX_Data_Valid && o_TX_Ready
//   (both sampled that edge). Push while o_TX_Ready=0 is dropped and sets
//   o_Overflow; this holds when a pop occurs on the same edge.
// - Pop: occurs on the edge where the FSM enters START. Push+pop on the
//   same edge leave count unchanged. All outputs are registered.
// - FSM: IDLE -> START (count>0) -> DATA (DATA_BITS bits) -> [PARITY]
//   -> STOP (STOP_BITS bits) -> START if count>0, else IDLE.
//   Each bit lasts exactly CLKS_PER_BIT cycles; baud counter counts
//   0..CLKS_PER_BIT-1 and resets on every bit boundary.
// - Latency: push at edge E into an empty FIFO with FSM in IDLE ->
//   start bit (serial=0) is driven from edge E+1 for CLKS_PER_BIT cycles.
// - Frame = 1 + DATA_BITS + P + STOP_BITS bits (P=1 with parity, else 0).
//   The byte is latched into a shift register at pop; later FIFO writes do
//   not affect the frame in flight.
// - o_TX_Active=1 from entry to START through the last STOP cycle. Stays 1
//   across back-to-back frames.
// - o_TX_Done=1 for the single cycle after the last stop-bit cycle, i.e.
//   on the edge that leaves STOP. Back-to-back: the next start bit begins
//   on that same edge, with no idle gap.
// - FIFO pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. The count
//   saturates at DEPTH; o_TX_Ready = (count != DEPTH).
// - DATA_BITS<9: upper port bits are unused. i_TX_Byte is DATA_BITS wide.
// CONFIGURATION
// - `define UART_PARITY_EN: PARITY state is present. The parity bit is the
//   XOR of the data bits, inverted when PARITY_ODD=1. It is sent after the
//   MSB for CLKS_PER_BIT cycles.
// - Without UART_PARITY_EN: no PARITY state, P=0, PARITY_ODD is ignored.
// TESTING (CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1, DEPTH=4 unless noted)
// - Reset, push 0xA5 -> serial 0,1,0,1,0,0,1,0,1,1, each bit held 4
//   cycles. o_TX_Done pulses once 40 cycles after the start bit begins.
// - Push 0x01,0x02,0x03 on consecutive cycles -> three frames with no idle
//   gap. o_TX_Active stays high, o_TX_Done pulses 3 times, count ends at 0.
// - Push 6 bytes in 6 cycles while FSM is busy -> 4 bytes are held, later
//   pushes dropped, o_Overflow=1 and stays 1 until reset.
// - Count==DEPTH, push on the pop edge -> push dropped, count=3 after.
// - UART_PARITY_EN, PARITY_ODD=0, push 0x07 -> parity bit 1. Same with
//   PARITY_ODD=1 -> parity bit 0. Frame is 11 bits (44 cycles).
// - Assert i_Rst_L low mid-DATA -> serial=1 and count=0 immediately, no
//   o_TX_Done. A push after release starts a clean frame.
// - STOP_BITS=2, DATA_BITS=5, push 0x1F -> 0,1,1,1,1,1,1,1, 32 cycles.

Source files
------------

// File: rtl/uart_tx_fifo_param.sv
// UART transmitter fed by a DEPTH-entry FIFO; frames go out back-to-back while data is queued.
// Optional parity bit is enabled with `define UART_PARITY_EN.
module uart_tx_fifo_param #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                     clk,
  input  logic                     i_Rst_L,
  input  logic                     i_TX_Data_Valid,
  input  logic [DATA_BITS-1:0]     i_TX_Byte,
  output logic                     o_TX_Ready,
  output logic [$clog2(DEPTH):0]   o_FIFO_Count,
  output logic                     o_Overflow,
  output logic                     o_TX_Active,
  output logic                     o_TX_Serial,
  output logic                     o_TX_Done
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

  localparam logic [BaudW-1:0] LastBaud = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       LastData = 4'(DATA_BITS - 1);
  localparam logic [3:0]       LastStop = 4'(STOP_BITS - 1);
  localparam logic [CntW-1:0]  Full     = CntW'(DEPTH);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;

  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_tx_fifo_param: illegal parameter combination");
  end

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q, count_d;
  logic                 ready_q, ovf_q;

  logic [2:0]           state_q, state_d;
  logic [BaudW-1:0]     baud_q, baud_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 serial_q, serial_d;
  logic                 active_q, active_d;
  logic                 done_q, done_d;
  logic                 push, pop, bit_end;
`ifdef UART_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  assign push    = i_TX_Data_Valid && ready_q;
  assign bit_end = (baud_q == LastBaud);

  always_comb begin
    state_d   = state_q;
    baud_d    = (state_q == StIdle || bit_end) ? '0 : baud_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    serial_d  = serial_q;
    active_d  = active_q;
    done_d    = 1'b0;
    pop       = 1'b0;
`ifdef UART_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      StIdle: pop = (count_q != '0);
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          bit_cnt_d = '0;
          serial_d  = shift_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_cnt_q == LastData) begin
`ifdef UART_PARITY_EN
            state_d  = StParity;
            serial_d = parity_q;
`else
            state_d   = StStop;
            serial_d  = 1'b1;
            bit_cnt_d = '0;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            shift_d   = shift_q >> 1;
            serial_d  = shift_q[1];
          end
        end
      end
`ifdef UART_PARITY_EN
      StParity: begin
        if (bit_end) begin
          state_d   = StStop;
          serial_d  = 1'b1;
          bit_cnt_d = '0;
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          if (bit_cnt_q == LastStop) begin
            done_d = 1'b1;
            // Chain straight into the next start bit when data is waiting.
            if (count_q != '0) begin
              pop = 1'b1;
            end else begin
              state_d  = StIdle;
              active_d = 1'b0;
              serial_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (pop) begin
      state_d  = StStart;
      serial_d = 1'b0;
      active_d = 1'b1;
      shift_d  = mem[rd_ptr_q];
`ifdef UART_PARITY_EN
      parity_d = (^mem[rd_ptr_q]) ^ (PARITY_ODD != 0);
`endif
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= i_TX_Byte;
  end

  always_ff @(posedge clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ready_q   <= 1'b1;
      ovf_q     <= 1'b0;
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q   <= count_d;
      ready_q   <= (count_d != Full);
      if (i_TX_Data_Valid && !ready_q) ovf_q <= 1'b1;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      serial_q  <= serial_d;
      active_q  <= active_d;
      done_q    <= done_d;
`ifdef UART_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign o_TX_Ready   = ready_q;
  assign o_FIFO_Count = count_q;
  assign o_Overflow   = ovf_q;
  assign o_TX_Active  = active_q;
  assign o_TX_Serial  = serial_q;
  assign o_TX_Done    = done_q;

endmodule
